// File: rtl/cvp14_mem_responder.sv
// cvp14_mem_responder
//   Memory-side responder for the CVP14 core bus. Accepts single-word or
//   16-beat vector burst reads and writes. A programmable number of wait
//   states precedes the first beat. Each beat is signalled by a one-cycle
//   Ready pulse.
//
// Ports
//   Clk1     : sole clock, rising edge
//   Reset    : asynchronous active-high reset
//   Addr     : word address from core (16 bits)
//   RD / WR  : read / write request; both high at once is a protocol error
//   V        : burst qualifier, sampled with RD/WR
//   dataOut  : write data from core, sampled on every write beat
//   DataIn   : registered read data to core; holds between read beats
//   Ready    : high for exactly the cycles in which a beat completes
//   Err      : one-cycle error pulse (RD&WR in idle, or out-of-range access)
module cvp14_mem_responder #(
   parameter int ADDR_W    = 8,
   parameter int WAIT_CYC  = 2,
   parameter int BURST_LEN = 16
) (
   input  logic        Clk1,
   input  logic        Reset,
   input  logic [15:0] Addr,
   input  logic        RD,
   input  logic        WR,
   input  logic        V,
   input  logic [15:0] dataOut,
   output logic [15:0] DataIn,
   output logic        Ready,
   output logic        Err
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int WCNT_W = (WAIT_CYC > 0)  ? $clog2(WAIT_CYC + 1) : 1;
   localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN)    : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_XFER = 2'd2
   } state_t;

   state_t              state_reg;
   logic [WCNT_W-1:0]   wait_cnt_reg;
   logic [BCNT_W-1:0]   beat_cnt_reg;
   logic [15:0]         addr_reg;
   logic                vec_reg;
   logic                wr_reg;

   logic [15:0]         mem [DEPTH];

   logic [ADDR_W-1:0]   beat_addr;
   logic                oor;
   logic                last_beat;
   logic                can_accept;

   // Burst addresses are taken from the low ADDR_W bits only, so the
   // natural ADDR_W-bit add gives the required wrap from top to word 0.
   assign beat_addr  = addr_reg[ADDR_W-1:0] + ADDR_W'(beat_cnt_reg);
   assign oor        = (addr_reg >> ADDR_W) != 16'd0;
   assign last_beat  = !vec_reg || (beat_cnt_reg == BCNT_W'(BURST_LEN - 1));
   // The final beat's edge doubles as an accept edge so back-to-back
   // requests need no idle bubble.
   assign can_accept = (state_reg == ST_IDLE) ||
                       ((state_reg == ST_XFER) && last_beat);

   // Array write port. Kept free of reset so the contents survive Reset;
   // state_reg is forced to IDLE by reset, which blocks any write.
   always_ff @(posedge Clk1) begin
      if (state_reg == ST_XFER && wr_reg && !oor) begin
         mem[beat_addr] <= dataOut;
      end
   end

   always_ff @(posedge Clk1 or posedge Reset) begin
      if (Reset) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= '0;
         beat_cnt_reg <= '0;
         addr_reg     <= '0;
         vec_reg      <= 1'b0;
         wr_reg       <= 1'b0;
         DataIn       <= 16'h0000;
         Ready        <= 1'b0;
         Err          <= 1'b0;
      end else begin
         Ready <= 1'b0;
         Err   <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
            end
            ST_WAIT: begin
               if (wait_cnt_reg <= WCNT_W'(1)) begin
                  state_reg <= ST_XFER;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - WCNT_W'(1);
               end
            end
            ST_XFER: begin
               Ready <= 1'b1;
               // Out-of-range is flagged once per request, on its first beat.
               if (oor && beat_cnt_reg == '0) begin
                  Err <= 1'b1;
               end
               if (!wr_reg) begin
                  DataIn <= oor ? 16'h0000 : mem[beat_addr];
               end
               if (last_beat) begin
                  state_reg    <= ST_IDLE;
                  beat_cnt_reg <= '0;
               end else begin
                  beat_cnt_reg <= beat_cnt_reg + BCNT_W'(1);
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase

         // Accepting overrides the IDLE transition taken on a last beat.
         if (can_accept) begin
            if (RD ^ WR) begin
               addr_reg     <= Addr;
               vec_reg      <= V;
               wr_reg       <= WR;
               beat_cnt_reg <= '0;
               wait_cnt_reg <= WCNT_W'(WAIT_CYC);
               state_reg    <= (WAIT_CYC == 0) ? ST_XFER : ST_WAIT;
            end else if (RD && WR) begin
               Err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cvp14_mem_responder.sv
module tb_cvp14_mem_responder;

   localparam int ADDR_W = 8;
   localparam int WAIT_A = 2;
   localparam int BLEN   = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [15:0] beat_arr_t [BLEN];

   logic        Clk1 = 1'b0;
   logic        Reset;
   logic [15:0] Addr, dataOut, DataIn;
   logic        RD, WR, V, Ready, Err;
   logic [15:0] addr0, dout0, din0;
   logic        rd0, wr0, v0, rdy0, err0;

   always #5 Clk1 = ~Clk1;

   cvp14_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_A), .BURST_LEN(BLEN)) u_dut (
      .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .V(V),
      .dataOut(dataOut), .DataIn(DataIn), .Ready(Ready), .Err(Err));

   cvp14_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(0), .BURST_LEN(BLEN)) u_dut0 (
      .Clk1(Clk1), .Reset(Reset), .Addr(addr0), .RD(rd0), .WR(wr0), .V(v0),
      .dataOut(dout0), .DataIn(din0), .Ready(rdy0), .Err(err0));

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: plain word array plus the last value returned by a read.
   logic [15:0] ref_mem [DEPTH];
   logic [15:0] last_rd;
   int          m_nb;
   beat_arr_t   m_rd;
   bit          m_oor;

   // Observations from the most recent transaction on u_dut.
   int          r_nrdy;
   int          r_lat [BLEN];
   beat_arr_t   r_rdat;
   bit          r_errb [BLEN];
   int          r_nerr;
   bit          r_dchg;
   logic        r_rst_rdy, r_rst_err;
   logic [15:0] r_rst_din;

   // Applies one request to the model; only the first nwr write beats land.
   task automatic model_txn(input bit wr, input bit v, input logic [15:0] addr,
                            input beat_arr_t wdata, input int nwr);
      m_nb  = v ? BLEN : 1;
      m_oor = (addr >> ADDR_W) != 16'd0;
      for (int i = 0; i < BLEN; i++) m_rd[i] = 16'h0000;
      for (int i = 0; i < m_nb; i++) begin
         int wa;
         wa = (int'(addr) + i) % DEPTH;
         if (wr) begin
            if (!m_oor && i < nwr) ref_mem[wa] = wdata[i];
         end else begin
            m_rd[i] = m_oor ? 16'h0000 : ref_mem[wa];
            last_rd = m_rd[i];
         end
      end
   endtask

   // Drives one request into u_dut and records every Ready beat. dataOut for
   // beat i is presented ahead of the edge 1+WAIT_A+i cycles after accept.
   // abort_k >= 0 asserts Reset right after observing cycle abort_k.
   task automatic run_txn(input bit rd, input bit wr, input bit v,
                          input logic [15:0] addr, input beat_arr_t wdata,
                          input int abort_k);
      int nb, ncyc;
      logic [15:0] d0;
      nb   = v ? BLEN : 1;
      ncyc = 2 + WAIT_A + nb;
      r_nrdy = 0; r_nerr = 0; r_dchg = 0;
      r_rst_rdy = 1'b0; r_rst_err = 1'b0; r_rst_din = 16'h0;
      for (int i = 0; i < BLEN; i++) begin
         r_lat[i] = -1; r_rdat[i] = 16'h0; r_errb[i] = 1'b0;
      end
      @(negedge Clk1);
      RD = rd; WR = wr; V = v; Addr = addr; dataOut = 16'($urandom);
      d0 = DataIn;
      for (int k = 0; k <= ncyc; k++) begin
         @(negedge Clk1);
         if (k > 0) begin
            if (Ready) begin
               if (r_nrdy < BLEN) begin
                  r_lat[r_nrdy]  = k;
                  r_rdat[r_nrdy] = DataIn;
                  r_errb[r_nrdy] = Err;
               end
               r_nrdy++;
            end
            if (Err) r_nerr++;
            if (DataIn !== d0) r_dchg = 1'b1;
         end
         if (k == abort_k) begin
            Reset = 1'b1;
            #1;
            r_rst_rdy = Ready; r_rst_err = Err; r_rst_din = DataIn;
            RD = 1'b0; WR = 1'b0;
            @(negedge Clk1);
            Reset = 1'b0;
            return;
         end
         // Junk on Addr/V while busy must be ignored.
         RD = 1'b0; WR = 1'b0; V = 1'($urandom); Addr = 16'($urandom);
         dataOut = (k - WAIT_A >= 0 && k - WAIT_A < nb) ? wdata[k - WAIT_A]
                                                        : 16'($urandom);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      RD = 0; WR = 0; V = 0; Addr = 0; dataOut = 0;
      rd0 = 0; wr0 = 0; v0 = 0; addr0 = 0; dout0 = 0;
      repeat (3) @(negedge Clk1);
      tests_run++; if (Ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", Ready); end
      tests_run++; if (Err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", Err); end
      tests_run++; if (DataIn !== 16'h0) begin tests_failed++; $display("FAIL reset_datain: got %h expected 0000", DataIn); end
      tests_run++; if (rdy0 !== 1'b0) begin tests_failed++; $display("FAIL reset_ready0: got %b expected 0", rdy0); end
      tests_run++; if (din0 !== 16'h0) begin tests_failed++; $display("FAIL reset_datain0: got %h expected 0000", din0); end
      Reset = 1'b0;
      last_rd = 16'h0;
      @(negedge Clk1);
      $display("[TB] reset: Ready=%b Err=%b DataIn=%h", Ready, Err, DataIn);
   endtask

   // Fills the whole array with known random data via bursts.
   task automatic test_fill();
      beat_arr_t wd;
      for (int blk = 0; blk < DEPTH / BLEN; blk++) begin
         for (int i = 0; i < BLEN; i++) wd[i] = 16'($urandom);
         run_txn(1'b0, 1'b1, 1'b1, 16'(blk * BLEN), wd, -1);
         model_txn(1'b1, 1'b1, 16'(blk * BLEN), wd, BLEN);
         tests_run++; if (r_nrdy !== BLEN) begin tests_failed++; $display("FAIL fill_beats: blk %0d got %0d expected %0d", blk, r_nrdy, BLEN); end
         tests_run++; if (r_nerr !== 0) begin tests_failed++; $display("FAIL fill_err: blk %0d got %0d expected 0", blk, r_nerr); end
         $display("[TB] fill burst write addr=%h beats=%0d", 16'(blk * BLEN), r_nrdy);
      end
   endtask

   task automatic test_single();
      beat_arr_t wd;
      for (int i = 0; i < BLEN; i++) wd[i] = 16'h0;
      wd[0] = 16'hBEEF;
      run_txn(1'b0, 1'b1, 1'b0, 16'h0010, wd, -1);
      model_txn(1'b1, 1'b0, 16'h0010, wd, BLEN);
      tests_run++; if (r_nrdy !== 1) begin tests_failed++; $display("FAIL single_wr_beats: got %0d expected 1", r_nrdy); end
      tests_run++; if (r_lat[0] !== 1 + WAIT_A) begin tests_failed++; $display("FAIL single_wr_lat: got %0d expected %0d", r_lat[0], 1 + WAIT_A); end
      tests_run++; if (r_dchg !== 1'b0) begin tests_failed++; $display("FAIL single_wr_hold: DataIn changed during write, expected hold"); end
      $display("[TB] single write addr=0010 data=BEEF lat=%0d", r_lat[0]);
      run_txn(1'b1, 1'b0, 1'b0, 16'h0010, wd, -1);
      model_txn(1'b0, 1'b0, 16'h0010, wd, BLEN);
      tests_run++; if (r_lat[0] !== 1 + WAIT_A) begin tests_failed++; $display("FAIL single_rd_lat: got %0d expected %0d", r_lat[0], 1 + WAIT_A); end
      tests_run++; if (r_rdat[0] !== 16'hBEEF) begin tests_failed++; $display("FAIL single_rd_data: got %h expected BEEF", r_rdat[0]); end
      tests_run++; if (r_nerr !== 0) begin tests_failed++; $display("FAIL single_err: got %0d expected 0", r_nerr); end
      $display("[TB] single read addr=0010 data=%h lat=%0d", r_rdat[0], r_lat[0]);
   endtask

   task automatic test_burst();
      beat_arr_t wd;
      for (int i = 0; i < BLEN; i++) wd[i] = 16'h1000 + 16'(i);
      run_txn(1'b0, 1'b1, 1'b1, 16'h0020, wd, -1);
      model_txn(1'b1, 1'b1, 16'h0020, wd, BLEN);
      tests_run++; if (r_nrdy !== BLEN) begin tests_failed++; $display("FAIL burst_wr_beats: got %0d expected %0d", r_nrdy, BLEN); end
      $display("[TB] burst write addr=0020 beats=%0d", r_nrdy);
      run_txn(1'b1, 1'b0, 1'b1, 16'h0020, wd, -1);
      model_txn(1'b0, 1'b1, 16'h0020, wd, BLEN);
      tests_run++; if (r_nrdy !== BLEN) begin tests_failed++; $display("FAIL burst_rd_beats: got %0d expected %0d", r_nrdy, BLEN); end
      for (int i = 0; i < BLEN; i++) begin
         tests_run++; if (r_lat[i] !== 1 + WAIT_A + i) begin tests_failed++; $display("FAIL burst_rd_lat: beat %0d got %0d expected %0d", i, r_lat[i], 1 + WAIT_A + i); end
         tests_run++; if (r_rdat[i] !== 16'h1000 + 16'(i)) begin tests_failed++; $display("FAIL burst_rd_data: beat %0d got %h expected %h", i, r_rdat[i], 16'h1000 + 16'(i)); end
      end
      $display("[TB] burst read addr=0020 beats=%0d last=%h", r_nrdy, r_rdat[BLEN-1]);
   endtask

   task automatic test_wrap();
      beat_arr_t wd;
      for (int i = 0; i < BLEN; i++) wd[i] = 16'($urandom);
      run_txn(1'b0, 1'b1, 1'b1, 16'h00F8, wd, -1);
      model_txn(1'b1, 1'b1, 16'h00F8, wd, BLEN);
      $display("[TB] wrap burst write addr=00F8 beats=%0d", r_nrdy);
      run_txn(1'b1, 1'b0, 1'b0, 16'h0003, wd, -1);
      model_txn(1'b0, 1'b0, 16'h0003, wd, BLEN);
      tests_run++; if (r_rdat[0] !== wd[11]) begin tests_failed++; $display("FAIL wrap_word3: got %h expected %h", r_rdat[0], wd[11]); end
      $display("[TB] wrap read addr=0003 data=%h", r_rdat[0]);
      run_txn(1'b1, 1'b0, 1'b1, 16'h00F8, wd, -1);
      model_txn(1'b0, 1'b1, 16'h00F8, wd, BLEN);
      for (int i = 0; i < BLEN; i++) begin
         tests_run++; if (r_rdat[i] !== wd[i]) begin tests_failed++; $display("FAIL wrap_rd_data: beat %0d got %h expected %h", i, r_rdat[i], wd[i]); end
      end
      $display("[TB] wrap burst read addr=00F8 beats=%0d", r_nrdy);
   endtask

   task automatic test_conflict_oor();
      beat_arr_t wd;
      for (int i = 0; i < BLEN; i++) wd[i] = 16'($urandom);
      @(negedge Clk1);
      RD = 1'b1; WR = 1'b1; V = 1'b0; Addr = 16'h0030; dataOut = 16'($urandom);
      @(negedge Clk1);
      tests_run++; if (Err !== 1'b1) begin tests_failed++; $display("FAIL conflict_err: got %b expected 1", Err); end
      tests_run++; if (Ready !== 1'b0) begin tests_failed++; $display("FAIL conflict_ready: got %b expected 0", Ready); end
      RD = 1'b0; WR = 1'b0;
      @(negedge Clk1);
      tests_run++; if (Err !== 1'b0) begin tests_failed++; $display("FAIL conflict_err_pulse: got %b expected 0", Err); end
      $display("[TB] RD&WR conflict: Err pulse seen, Ready=%b", Ready);
      run_txn(1'b1, 1'b0, 1'b0, 16'h0030, wd, -1);
      model_txn(1'b0, 1'b0, 16'h0030, wd, BLEN);
      tests_run++; if (r_rdat[0] !== m_rd[0]) begin tests_failed++; $display("FAIL conflict_nowrite: got %h expected %h", r_rdat[0], m_rd[0]); end
      run_txn(1'b1, 1'b0, 1'b0, 16'h0105, wd, -1);
      model_txn(1'b0, 1'b0, 16'h0105, wd, BLEN);
      tests_run++; if (r_nrdy !== 1) begin tests_failed++; $display("FAIL oor_rd_beats: got %0d expected 1", r_nrdy); end
      tests_run++; if (r_rdat[0] !== 16'h0000) begin tests_failed++; $display("FAIL oor_rd_data: got %h expected 0000", r_rdat[0]); end
      tests_run++; if (r_errb[0] !== 1'b1) begin tests_failed++; $display("FAIL oor_rd_err: got %b expected 1", r_errb[0]); end
      $display("[TB] oor read addr=0105 data=%h err=%b", r_rdat[0], r_errb[0]);
      run_txn(1'b0, 1'b1, 1'b1, 16'h0107, wd, -1);
      model_txn(1'b1, 1'b1, 16'h0107, wd, BLEN);
      tests_run++; if (r_nrdy !== BLEN) begin tests_failed++; $display("FAIL oor_wr_beats: got %0d expected %0d", r_nrdy, BLEN); end
      tests_run++; if (r_nerr !== 1) begin tests_failed++; $display("FAIL oor_wr_errcount: got %0d expected 1", r_nerr); end
      run_txn(1'b1, 1'b0, 1'b1, 16'h0007, wd, -1);
      model_txn(1'b0, 1'b1, 16'h0007, wd, BLEN);
      for (int i = 0; i < BLEN; i++) begin
         tests_run++; if (r_rdat[i] !== m_rd[i]) begin tests_failed++; $display("FAIL oor_wr_dropped: beat %0d got %h expected %h", i, r_rdat[i], m_rd[i]); end
      end
      $display("[TB] oor burst write addr=0107 dropped, readback of 0007 done");
   endtask

   task automatic test_random();
      beat_arr_t wd;
      bit rdop, vb;
      logic [15:0] a;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < BLEN; i++) wd[i] = 16'($urandom);
         rdop = 1'($urandom);
         vb   = 1'($urandom);
         a    = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                            : 16'($urandom_range(0, DEPTH - 1));
         run_txn(rdop, !rdop, vb, a, wd, -1);
         model_txn(!rdop, vb, a, wd, BLEN);
         tests_run++; if (r_nrdy !== m_nb) begin tests_failed++; $display("FAIL rand_beats: txn %0d got %0d expected %0d", t, r_nrdy, m_nb); end
         tests_run++; if (r_nerr !== int'(m_oor)) begin tests_failed++; $display("FAIL rand_errcount: txn %0d got %0d expected %0d", t, r_nerr, int'(m_oor)); end
         tests_run++; if (r_errb[0] !== m_oor) begin tests_failed++; $display("FAIL rand_err_first: txn %0d got %b expected %b", t, r_errb[0], m_oor); end
         for (int i = 0; i < m_nb; i++) begin
            tests_run++; if (r_lat[i] !== 1 + WAIT_A + i) begin tests_failed++; $display("FAIL rand_lat: txn %0d beat %0d got %0d expected %0d", t, i, r_lat[i], 1 + WAIT_A + i); end
            if (rdop) begin
               tests_run++; if (r_rdat[i] !== m_rd[i]) begin tests_failed++; $display("FAIL rand_rd_data: txn %0d beat %0d got %h expected %h", t, i, r_rdat[i], m_rd[i]); end
            end
         end
         if (!rdop) begin
            tests_run++; if (r_dchg !== 1'b0) begin tests_failed++; $display("FAIL rand_wr_hold: txn %0d DataIn changed during write, expected hold", t); end
         end
         $display("[TB] rand txn %0d %s V=%b addr=%h beats=%0d oor=%b", t, rdop ? "RD" : "WR", vb, a, r_nrdy, m_oor);
      end
   endtask

   task automatic test_reset_midburst();
      beat_arr_t wd;
      for (int i = 0; i < BLEN; i++) wd[i] = 16'h0;
      wd[0] = 16'hA5A5;
      run_txn(1'b0, 1'b1, 1'b0, 16'h0000, wd, -1);
      model_txn(1'b1, 1'b0, 16'h0000, wd, BLEN);
      run_txn(1'b1, 1'b0, 1'b0, 16'h0000, wd, -1);
      model_txn(1'b0, 1'b0, 16'h0000, wd, BLEN);
      for (int i = 0; i < BLEN; i++) wd[i] = 16'($urandom);
      run_txn(1'b0, 1'b1, 1'b1, 16'h0040, wd, 1 + WAIT_A + 4);
      model_txn(1'b1, 1'b1, 16'h0040, wd, 5);
      last_rd = 16'h0;
      tests_run++; if (r_nrdy !== 5) begin tests_failed++; $display("FAIL abort_beats_before: got %0d expected 5", r_nrdy); end
      tests_run++; if (r_rst_rdy !== 1'b0) begin tests_failed++; $display("FAIL abort_ready: got %b expected 0", r_rst_rdy); end
      tests_run++; if (r_rst_err !== 1'b0) begin tests_failed++; $display("FAIL abort_err: got %b expected 0", r_rst_err); end
      tests_run++; if (r_rst_din !== 16'h0) begin tests_failed++; $display("FAIL abort_datain: got %h expected 0000", r_rst_din); end
      $display("[TB] reset mid-burst at beat 5: Ready=%b DataIn=%h", r_rst_rdy, r_rst_din);
      run_txn(1'b1, 1'b0, 1'b1, 16'h0040, wd, -1);
      model_txn(1'b0, 1'b1, 16'h0040, wd, BLEN);
      for (int i = 0; i < BLEN; i++) begin
         tests_run++; if (r_rdat[i] !== m_rd[i]) begin tests_failed++; $display("FAIL abort_readback: beat %0d got %h expected %h", i, r_rdat[i], m_rd[i]); end
      end
      $display("[TB] post-abort burst read addr=0040 beats=%0d", r_nrdy);
   endtask

   // Zero-wait instance: each request is issued on the previous final-beat edge.
   task automatic test_back_to_back();
      logic [15:0] a, b, x, y;
      a = 16'($urandom_range(0, 127));
      b = a + 16'd128;
      x = 16'($urandom_range(1, 65535));
      y = ~x;
      @(negedge Clk1);
      wr0 = 1'b1; rd0 = 1'b0; v0 = 1'b0; addr0 = a; dout0 = x;   // accepted at edge n
      @(negedge Clk1);
      tests_run++; if (rdy0 !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept_ready: got %b expected 0", rdy0); end
      addr0 = b; dout0 = x;                                       // edge n+1: beat A, accept B
      @(negedge Clk1);
      tests_run++; if (rdy0 !== 1'b1) begin tests_failed++; $display("FAIL b2b_wr_a_ready: got %b expected 1", rdy0); end
      tests_run++; if (din0 !== 16'h0) begin tests_failed++; $display("FAIL b2b_wr_hold: got %h expected 0000", din0); end
      wr0 = 1'b0; rd0 = 1'b1; addr0 = a; dout0 = y;               // edge n+2: beat B, accept read A
      @(negedge Clk1);
      tests_run++; if (rdy0 !== 1'b1) begin tests_failed++; $display("FAIL b2b_wr_b_ready: got %b expected 1", rdy0); end
      addr0 = b;                                                  // edge n+3: read A beat, accept read B
      @(negedge Clk1);
      tests_run++; if (rdy0 !== 1'b1) begin tests_failed++; $display("FAIL b2b_rd_a_ready: got %b expected 1", rdy0); end
      tests_run++; if (din0 !== x) begin tests_failed++; $display("FAIL b2b_rd_a_data: got %h expected %h", din0, x); end
      rd0 = 1'b0;                                                 // edge n+4: read B beat
      @(negedge Clk1);
      tests_run++; if (rdy0 !== 1'b1) begin tests_failed++; $display("FAIL b2b_rd_b_ready: got %b expected 1", rdy0); end
      tests_run++; if (din0 !== y) begin tests_failed++; $display("FAIL b2b_rd_b_data: got %h expected %h", din0, y); end
      @(negedge Clk1);
      tests_run++; if (rdy0 !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle_ready: got %b expected 0", rdy0); end
      tests_run++; if (din0 !== y) begin tests_failed++; $display("FAIL b2b_idle_hold: got %h expected %h", din0, y); end
      tests_run++; if (err0 !== 1'b0) begin tests_failed++; $display("FAIL b2b_err: got %b expected 0", err0); end
      $display("[TB] back-to-back WAIT=0: wr %h, wr %h, rd %h=%h, rd %h", a, b, a, x, b);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_single();
      test_burst();
      test_wrap();
      test_conflict_oor();
      test_random();
      test_reset_midburst();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cvp14_mem_responder.md
Name: cvp14_mem_responder

Overview:
- Memory-side responder for the CVP14 core bus: services the core's Addr/RD/WR/V/dataOut requests and drives DataIn back.
- Holds a 2^ADDR_W x 16-bit word array.
- Inserts a programmable number of wait states before each transfer.
- V=1 selects a 16-beat sequential burst for VLD/VST; V=0 selects a single-word access for scalar loads/stores and instruction fetch.
- Ready tells the core when a beat has completed.

Parameters:
ADDR_W, 8, word-address width of internal array (depth 2^ADDR_W)
WAIT_CYC, 2, wait-state cycles between request accept and first beat (0 allowed)
BURST_LEN, 16, beats per vector burst (one per 16-bit lane of a 256-bit vector)

Ports:
Clk1  input  1  sole clock, rising edge
Reset  input  1  asynchronous, active-high reset
Addr  input  16  word address from core
RD  input  1  read request
WR  input  1  write request
V  input  1  vector burst qualifier, sampled with RD/WR
dataOut  input  16  write data from core, sampled on each write beat
DataIn  output  16  registered read data to core
Ready  output  1  high for exactly the cycles in which a beat completes
Err  output  1  error flag, one-cycle pulse

Behaviour:
- Reset (async, any state) forces:
  - State=IDLE, Ready=0, Err=0, DataIn=16'h0000, wait and beat counters=0.
  - Memory array is not cleared.
  - Reset mid-burst aborts the burst; beats already written persist.
- States: IDLE, WAIT, XFER.
- IDLE:
  - RD^WR sampled high at an edge accepts the request.
  - Latch Addr, V, op (read/write).
  - Go to WAIT with counter=WAIT_CYC, or directly to XFER if WAIT_CYC=0.
  - RD&WR both high: no access, Err=1 for one cycle, stay IDLE.
  - Neither high: stay IDLE, outputs idle.
- WAIT: decrement counter each cycle; go to XFER when it reaches 1. RD/WR/Addr/V changes are ignored.
- XFER, each cycle is one beat:
  - Ready=1.
  - Read: DataIn=mem[beat address].
  - Write: mem[beat address] <= dataOut sampled this cycle.
  - Single access (V=0): one beat, then IDLE.
  - Burst (V=1): BURST_LEN consecutive beats with no bubbles. Beat address = latched Addr + beat index, modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0). Return to IDLE after the last beat.
- Latency:
  - Request sampled at edge n.
  - First Ready-high cycle begins after edge n+1+WAIT_CYC; DataIn is valid in that same cycle.
  - Burst's last beat is at edge n+WAIT_CYC+BURST_LEN.
- IDLE resumes accepting at the edge after the final beat; back-to-back requests are allowed with no extra idle cycle.
- DataIn holds its last read value while Ready=0, and also during write beats.
- Out of range (latched Addr[15:ADDR_W] != 0):
  - Handshake completes normally.
  - Err=1 coincident with the first beat only.
  - Reads return 16'h0000; writes are dropped.
  - Burst beats use the low ADDR_W bits, but data stays zeroed/dropped for the whole burst.
- Read-after-write in consecutive requests returns the new data; there is no stale-read hazard.
- Ready and Err are never high in IDLE except Err for the RD&WR case.

Test Plan:
- Reset, WAIT_CYC=2: single write Addr=16'h0010, dataOut=16'hBEEF, then single read Addr=16'h0010 -> write Ready high 3 cycles after accept; read Ready 3 cycles after accept with DataIn=16'hBEEF; Err=0 throughout.
- Vector burst write at Addr=16'h0020, dataOut=16'h1000+i for beats i=0..15, then V=1 read of same -> 16 contiguous Ready cycles each; read beat i returns 16'h1000+i.
- Burst at Addr=16'h00F8, ADDR_W=8 -> beats 8..15 hit words 0x00..0x07 (wrap); readback of word 0x03 returns beat 11 data.
- RD=WR=1 in IDLE -> Err high one cycle, Ready stays 0, no memory change; then a single read of Addr=16'h0105 -> Ready with DataIn=16'h0000 and Err=1 on that beat.
- Assert Reset at burst beat 5 of a write -> Ready/Err/DataIn drop to 0 asynchronously, state IDLE; read of beat addresses 0..4 returns new data, 5..15 old data.
- WAIT_CYC=0 build: read accepted at edge n -> Ready at edge n+1; back-to-back read issued on that last-beat edge is accepted with Ready again at n+2.
